mem_stage_ctrl: RTL
===================

MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

Interface
REQ-001 SHALL have port clk  input  1  sole clock, rising-edge.
REQ-002 SHALL have port rst_n  input  1  reset; one clock, asynchronous, active-low.
REQ-003 SHALL have ports ex_valid  input  1  and ex_control  input  lc3b_control_word: the EX/MEM instruction.
REQ-004 SHALL have ports ex_dest  input  lc3b_reg, ex_alu_out  input  16  (ALU result), ex_addr  input  16  (branch-adder address) and ex_sr2_data  input  16  (forwarded store data).
REQ-005 SHALL have ports dmem_address  output  16, dmem_read  output  1, dmem_write  output  1, dmem_wmask  output  2, dmem_wdata  output  16, dmem_rdata  input  16 and dmem_resp  input  1.
REQ-006 SHALL have ports mem_control  output  lc3b_control_word, mem_dest  output  lc3b_reg, mem_alu_out  output  16, mem_load_data  output  16 and mem_valid  output  1: the MEM-stage view used by forwarding.
REQ-007 SHALL have ports wb_control  output  lc3b_control_word, wb_dest  output  lc3b_reg, wb_data  output  16 and wb_valid  output  1: the registered MEM/WB outputs.
REQ-008 SHALL have port stall  output  1: freezes IF, ID, EX and the EX/MEM register.

Function
REQ-009 SHALL pass mem_control, mem_dest and mem_alu_out through combinationally from the EX/MEM inputs; mem_valid = ex_valid.
REQ-010 SHALL implement FSM states IDLE, ACCESS1 and ACCESS2.
REQ-011 SHALL, in IDLE, go to ACCESS1 when ex_valid and the opcode is one of op_ldr, op_ldb, op_ldi, op_str, op_stb, op_sti; all other opcodes SHALL remain in IDLE with zero added latency.
REQ-012 SHALL, in ACCESS1, drive dmem_address = ex_addr; word ops SHALL force bit 0 to 0.
REQ-013 SHALL, for LDR, LDB, LDI and STI in ACCESS1, assert dmem_read; for STR and STB in ACCESS1, assert dmem_write.
REQ-014 SHALL hold all dmem outputs stable until dmem_resp.
REQ-015 SHALL, on dmem_resp in ACCESS1 for LDI or STI, latch dmem_rdata into an internal pointer register and go to ACCESS2.
REQ-016 SHALL, on dmem_resp in ACCESS1 for any other memory op, go to IDLE.
REQ-017 SHALL, in ACCESS2, drive dmem_address = {pointer[15:1],0}; LDI SHALL assert dmem_read and STI SHALL assert dmem_write; on dmem_resp the FSM SHALL go to IDLE.
REQ-018 SHALL drive stall = 1 whenever a memory op is active and dmem_resp is not completing its final access this cycle.
REQ-019 SHALL, for STB, drive dmem_wmask = 2'b10 if address bit 0 is 1 and 2'b01 otherwise; dmem_wdata SHALL be {sr2[7:0], sr2[7:0]}.
REQ-020 SHALL, for STR and STI, drive dmem_wmask = 2'b11 and dmem_wdata = ex_sr2_data.
REQ-021 SHALL, for LDB, set mem_load_data to the selected byte sign-extended to 16 bits; LDR and LDI SHALL set it to dmem_rdata.
REQ-022 SHALL select wb_data as mem_load_data for loads, ex_addr for op_lea, and ex_alu_out otherwise.
REQ-023 SHALL capture wb_* on a clock edge only when stall = 0; while stalled, wb_valid SHALL be 0 (bubble) and wb_control.load_regfile SHALL be 0.
REQ-024 SHALL, with ex_valid = 0, issue no memory request and produce wb_valid = 0.
REQ-025 SHALL treat a dmem_resp arriving in IDLE as ignored.
REQ-026 SHALL, when dmem_resp is asserted in the same cycle the request first asserts, complete the access that cycle (minimum 1-cycle latency).

Reset
REQ-027 SHALL, on rst_n low, immediately force the FSM to IDLE, the pointer to 0, and wb_valid, wb_data, wb_dest and wb_control to 0.
REQ-028 SHALL, on reset mid-access, abandon the outstanding request, with dmem_read and dmem_write going low asynchronously.

Structure
REQ-029 SHALL keep lc3b_control_word, lc3b_reg, lc3b_word, the opcode enum and the new mem_state enum (IDLE/ACCESS1/ACCESS2) in lc3b_types.
REQ-030 SHALL place the byte-select, sign-extend and store-replicate logic in one sub-module named load_store_align.

Verification
REQ-031 SHALL cover: LDR, ex_addr = 0x3001, resp after 3 cycles -> dmem_address = 0x3000; stall high 3 cycles; wb_data = 0xBEEF.
REQ-032 SHALL cover: LDB, addr = 0x2005, rdata = 0x80FF -> wb_data = 0xFF80.
REQ-033 SHALL cover: STB, addr = 0x2004, sr2 = 0x1234 -> wmask = 01, wdata = 0x3434.
REQ-034 SHALL cover: LDI, addr = 0x4000, first rdata = 0x5001, second rdata = 0x00AA -> second dmem_address = 0x5000; wb_data = 0x00AA.
REQ-035 SHALL cover: ADD followed by STI with immediate resp -> ADD reaches WB with no stall; STI stalls exactly 1 cycle.
REQ-036 SHALL cover: rst_n low during ACCESS2 -> FSM IDLE and dmem_read = 0 in the same cycle, wb_valid = 0.

Source files
------------

// File: rtl/lc3b_types.sv
// Shared LC-3b pipeline types: words, registers, opcodes, control word and MEM-stage FSM states.
// Pure declarations and opcode classifiers; no logic, latency or flow control of its own.
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [2:0]  lc3b_reg;

  typedef enum logic [3:0] {
    op_br   = 4'b0000,
    op_add  = 4'b0001,
    op_ldb  = 4'b0010,
    op_stb  = 4'b0011,
    op_jsr  = 4'b0100,
    op_and  = 4'b0101,
    op_ldr  = 4'b0110,
    op_str  = 4'b0111,
    op_rti  = 4'b1000,
    op_not  = 4'b1001,
    op_ldi  = 4'b1010,
    op_sti  = 4'b1011,
    op_jmp  = 4'b1100,
    op_shf  = 4'b1101,
    op_lea  = 4'b1110,
    op_trap = 4'b1111
  } lc3b_opcode;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS1 = 2'd1,
    ACCESS2 = 2'd2
  } mem_state;

  typedef struct packed {
    lc3b_opcode opcode;
    logic       load_regfile;
    logic       load_cc;
  } lc3b_control_word;

  function automatic logic is_mem_op(input lc3b_opcode op);
    return op inside {op_ldr, op_ldb, op_ldi, op_str, op_stb, op_sti};
  endfunction

  function automatic logic is_load_op(input lc3b_opcode op);
    return op inside {op_ldr, op_ldb, op_ldi};
  endfunction

  function automatic logic is_indirect_op(input lc3b_opcode op);
    return op inside {op_ldi, op_sti};
  endfunction

  // Byte ops keep the full byte address; everything else touches aligned words.
  function automatic logic is_word_op(input lc3b_opcode op);
    return op inside {op_ldr, op_ldi, op_str, op_sti};
  endfunction

endpackage

// File: rtl/load_store_align.sv
// Byte lane handling for loads and stores: byte select + sign-extend, store replicate and write mask.
// Purely combinational, zero latency; no flow control.
module load_store_align
  import lc3b_types::*;
(
  input  lc3b_opcode op_i,
  input  logic       addr_lsb_i,
  input  lc3b_word   rdata_i,
  input  lc3b_word   sr2_i,
  output lc3b_word   load_data_o,
  output lc3b_word   wdata_o,
  output logic [1:0] wmask_o
);

  logic [7:0] byte_sel;

  assign byte_sel = addr_lsb_i ? rdata_i[15:8] : rdata_i[7:0];

  always_comb begin
    load_data_o = rdata_i;
    wdata_o     = sr2_i;
    wmask_o     = 2'b11;
    if (op_i == op_ldb) begin
      load_data_o = {{8{byte_sel[7]}}, byte_sel};
    end
    // Replicating the byte lets the mask alone pick the target lane.
    if (op_i == op_stb) begin
      wdata_o = {sr2_i[7:0], sr2_i[7:0]};
      wmask_o = addr_lsb_i ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// LC-3b MEM stage: drives data memory for loads/stores (LDI/STI take two accesses) and registers MEM/WB.
// Requests issue the cycle the op arrives; stall holds upstream until the final dmem_resp, WB gets bubbles meanwhile.
module mem_stage_ctrl
  import lc3b_types::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid,
  input  lc3b_control_word ex_control,
  input  lc3b_reg          ex_dest,
  input  logic [15:0]      ex_alu_out,
  input  logic [15:0]      ex_addr,
  input  logic [15:0]      ex_sr2_data,
  output logic [15:0]      dmem_address,
  output logic             dmem_read,
  output logic             dmem_write,
  output logic [1:0]       dmem_wmask,
  output logic [15:0]      dmem_wdata,
  input  logic [15:0]      dmem_rdata,
  input  logic             dmem_resp,
  output lc3b_control_word mem_control,
  output lc3b_reg          mem_dest,
  output logic [15:0]      mem_alu_out,
  output logic [15:0]      mem_load_data,
  output logic             mem_valid,
  output lc3b_control_word wb_control,
  output lc3b_reg          wb_dest,
  output logic [15:0]      wb_data,
  output logic             wb_valid,
  output logic             stall
);

  mem_state         state_q, state_d;
  logic [15:1]      ptr_q, ptr_d;
  logic             wb_valid_q, wb_valid_d;
  lc3b_word         wb_data_q, wb_data_d;
  lc3b_reg          wb_dest_q, wb_dest_d;
  lc3b_control_word wb_control_q, wb_control_d;

  lc3b_opcode op;
  logic       mem_op;
  logic       phase1;
  logic       phase2;
  logic       final_done;
  logic [1:0] align_mask;
  lc3b_word   align_wdata;
  lc3b_word   load_data;

  assign op = ex_control.opcode;

  // Gating with rst_n drops any outstanding request the moment reset asserts.
  assign mem_op = rst_n && ex_valid && is_mem_op(op);

  // The first access is driven straight from IDLE so a same-cycle response costs no stall.
  assign phase1 = mem_op && (state_q == IDLE || state_q == ACCESS1);
  assign phase2 = mem_op && (state_q == ACCESS2);

  assign final_done = dmem_resp && ((phase1 && !is_indirect_op(op)) || phase2);
  assign stall      = (phase1 || phase2) && !final_done;

  load_store_align u_align (
    .op_i        (op),
    .addr_lsb_i  (ex_addr[0]),
    .rdata_i     (dmem_rdata),
    .sr2_i       (ex_sr2_data),
    .load_data_o (load_data),
    .wdata_o     (align_wdata),
    .wmask_o     (align_mask)
  );

  always_comb begin
    dmem_address = ex_addr;
    if (phase2) begin
      dmem_address = {ptr_q, 1'b0};
    end else if (is_word_op(op)) begin
      dmem_address = {ex_addr[15:1], 1'b0};
    end
  end

  assign dmem_read  = (phase1 && (is_load_op(op) || op == op_sti)) || (phase2 && op == op_ldi);
  assign dmem_write = (phase1 && (op == op_str || op == op_stb)) || (phase2 && op == op_sti);
  assign dmem_wmask = dmem_write ? align_mask : 2'b00;
  assign dmem_wdata = align_wdata;

  assign mem_control   = ex_control;
  assign mem_dest      = ex_dest;
  assign mem_alu_out   = ex_alu_out;
  assign mem_load_data = load_data;
  assign mem_valid     = ex_valid;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE, ACCESS1: begin
        if (!mem_op) begin
          state_d = IDLE;
        end else if (dmem_resp) begin
          if (is_indirect_op(op)) begin
            ptr_d   = dmem_rdata[15:1];
            state_d = ACCESS2;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = ACCESS1;
        end
      end
      ACCESS2: begin
        if (!mem_op || dmem_resp) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wb_valid_d   = wb_valid_q;
    wb_data_d    = wb_data_q;
    wb_dest_d    = wb_dest_q;
    wb_control_d = wb_control_q;
    if (stall) begin
      wb_valid_d                = 1'b0;
      wb_control_d.load_regfile = 1'b0;
    end else begin
      wb_valid_d                = ex_valid;
      wb_dest_d                 = ex_dest;
      wb_control_d              = ex_control;
      wb_control_d.load_regfile = ex_control.load_regfile && ex_valid;
      if (is_load_op(op)) begin
        wb_data_d = load_data;
      end else if (op == op_lea) begin
        wb_data_d = ex_addr;
      end else begin
        wb_data_d = ex_alu_out;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      wb_valid_q   <= 1'b0;
      wb_data_q    <= '0;
      wb_dest_q    <= '0;
      wb_control_q <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      wb_valid_q   <= wb_valid_d;
      wb_data_q    <= wb_data_d;
      wb_dest_q    <= wb_dest_d;
      wb_control_q <= wb_control_d;
    end
  end

  assign wb_valid   = wb_valid_q;
  assign wb_data    = wb_data_q;
  assign wb_dest    = wb_dest_q;
  assign wb_control = wb_control_q;

endmodule
